// File: rtl/mem_arbiter.sv
// Round-robin arbiter putting two single-byte masters onto one shared RAM port.
// Each transaction is IDLE -> ACCESS -> RESP. The RAM samples on the falling edge inside ACCESS.
module mem_arbiter #(
  parameter int DATAWIDTH   = 8,
  parameter int ADRESSWIDTH = 12
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   m0_req,
  input  logic                   m0_we,
  input  logic [ADRESSWIDTH-1:0] m0_address,
  input  logic [DATAWIDTH-1:0]   m0_dataout,
  output logic [DATAWIDTH-1:0]   m0_datain,
  output logic                   m0_ack,
  input  logic                   m1_req,
  input  logic                   m1_we,
  input  logic [ADRESSWIDTH-1:0] m1_address,
  input  logic [DATAWIDTH-1:0]   m1_dataout,
  output logic [DATAWIDTH-1:0]   m1_datain,
  output logic                   m1_ack,
  output logic [ADRESSWIDTH-1:0] ram_address,
  output logic                   ram_we,
  output logic [DATAWIDTH-1:0]   ram_dataout,
  input  logic [DATAWIDTH-1:0]   ram_datain,
  output logic                   busy,
  output logic                   grant
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                 state_q, state_d;
  logic                   last_q, last_d;
  logic                   grant_q, grant_d;
  logic [ADRESSWIDTH-1:0] ram_address_q, ram_address_d;
  logic                   ram_we_q, ram_we_d;
  logic [DATAWIDTH-1:0]   ram_dataout_q, ram_dataout_d;
  logic [DATAWIDTH-1:0]   m0_datain_q, m0_datain_d;
  logic [DATAWIDTH-1:0]   m1_datain_q, m1_datain_d;
  logic                   m0_ack_q, m0_ack_d;
  logic                   m1_ack_q, m1_ack_d;
  logic                   sel;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      grant_q       <= 1'b0;
      ram_address_q <= '0;
      ram_we_q      <= 1'b0;
      ram_dataout_q <= '0;
      m0_datain_q   <= '0;
      m1_datain_q   <= '0;
      m0_ack_q      <= 1'b0;
      m1_ack_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      grant_q       <= grant_d;
      ram_address_q <= ram_address_d;
      ram_we_q      <= ram_we_d;
      ram_dataout_q <= ram_dataout_d;
      m0_datain_q   <= m0_datain_d;
      m1_datain_q   <= m1_datain_d;
      m0_ack_q      <= m0_ack_d;
      m1_ack_q      <= m1_ack_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    grant_d       = grant_q;
    ram_address_d = ram_address_q;
    ram_dataout_d = ram_dataout_q;
    m0_datain_d   = m0_datain_q;
    m1_datain_d   = m1_datain_q;
    ram_we_d      = 1'b0;
    m0_ack_d      = 1'b0;
    m1_ack_d      = 1'b0;
    sel           = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the master not served last wins; otherwise the lone requester.
          sel           = (m0_req && m1_req) ? ~last_q : m1_req;
          grant_d       = sel;
          last_d        = sel;
          ram_address_d = sel ? m1_address : m0_address;
          ram_dataout_d = sel ? m1_dataout : m0_dataout;
          ram_we_d      = sel ? m1_we : m0_we;
          state_d       = ACCESS;
        end
      end
      ACCESS: begin
        if (grant_q) begin
          m1_datain_d = ram_datain;
          m1_ack_d    = 1'b1;
        end else begin
          m0_datain_d = ram_datain;
          m0_ack_d    = 1'b1;
        end
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign m0_datain   = m0_datain_q;
  assign m1_datain   = m1_datain_q;
  assign m0_ack      = m0_ack_q;
  assign m1_ack      = m1_ack_q;
  assign ram_address = ram_address_q;
  assign ram_we      = ram_we_q;
  assign ram_dataout = ram_dataout_q;
  assign busy        = (state_q != IDLE);
  assign grant       = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Cycle-by-cycle vector bench for mem_arbiter with a behavioural RAM model on the falling edge.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [11:0] m0_address, m1_address, ram_address;
  logic [7:0]  m0_dataout, m1_dataout, m0_datain, m1_datain;
  logic [7:0]  ram_dataout, ram_datain;
  logic        m0_ack, m1_ack, ram_we, busy, grant;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.DATAWIDTH(8), .ADRESSWIDTH(12)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_address(m0_address), .m0_dataout(m0_dataout),
    .m0_datain(m0_datain), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_address(m1_address), .m1_dataout(m1_dataout),
    .m1_datain(m1_datain), .m1_ack(m1_ack),
    .ram_address(ram_address), .ram_we(ram_we), .ram_dataout(ram_dataout),
    .ram_datain(ram_datain), .busy(busy), .grant(grant)
  );

  always #5 clock = ~clock;

  // Write-first RAM: a write also returns the written byte.
  logic [7:0] mem [0:4095];
  always @(negedge clock) begin
    if (ram_we) begin
      mem[ram_address] <= ram_dataout;
      ram_datain       <= ram_dataout;
    end else begin
      ram_datain <= mem[ram_address];
    end
  end

  typedef struct {
    logic       rst;
    logic       r0, w0;
    logic [11:0] a0;
    logic [7:0] d0;
    logic       r1, w1;
    logic [11:0] a1;
    logic [7:0] d1;
    logic [45:0] exp;  // {busy,grant,ram_we,ram_address,ram_dataout,m0_ack,m1_ack,m0_datain,m1_datain}
  } vec_t;

  vec_t vecs [0:33];

  function automatic vec_t mk(logic rst, logic r0, logic w0, logic [11:0] a0, logic [7:0] d0,
                              logic r1, logic w1, logic [11:0] a1, logic [7:0] d1,
                              logic eb, logic eg, logic ew, logic [11:0] ea, logic [7:0] ed,
                              logic ek0, logic ek1, logic [7:0] ei0, logic [7:0] ei1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.exp = {eb, eg, ew, ea, ed, ek0, ek1, ei0, ei1};
    return v;
  endfunction

  function automatic logic [45:0] outs();
    return {busy, grant, ram_we, ram_address, ram_dataout, m0_ack, m1_ack, m0_datain, m1_datain};
  endfunction

  task automatic check(string name, logic [45:0] act, logic [45:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive(vec_t v);
    reset = v.rst;
    m0_req = v.r0; m0_we = v.w0; m0_address = v.a0; m0_dataout = v.d0;
    m1_req = v.r1; m1_we = v.w1; m1_address = v.a1; m1_dataout = v.d1;
  endtask

  initial begin
    int n;
    logic got, m0_seen;
    // Tracking state per row: both masters, then expected outputs after the edge.
    vecs[0]  = mk(1, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,0,12'h000,8'h00,0,0,8'h00,8'h00);
    vecs[1]  = mk(0, 1,1,12'h123,8'hA5, 0,0,12'h000,8'h00, 1,0,1,12'h123,8'hA5,0,0,8'h00,8'h00);
    vecs[2]  = mk(0, 1,1,12'h123,8'hA5, 0,0,12'h000,8'h00, 1,0,0,12'h123,8'hA5,1,0,8'hA5,8'h00);
    vecs[3]  = mk(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,0,12'h123,8'hA5,0,0,8'hA5,8'h00);
    vecs[4]  = mk(0, 0,0,12'h000,8'h00, 1,0,12'h123,8'h00, 1,1,0,12'h123,8'h00,0,0,8'hA5,8'h00);
    vecs[5]  = mk(0, 0,0,12'h000,8'h00, 1,0,12'h123,8'h00, 1,1,0,12'h123,8'h00,0,1,8'hA5,8'hA5);
    vecs[6]  = mk(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,1,0,12'h123,8'h00,0,0,8'hA5,8'hA5);
    vecs[7]  = mk(1, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,0,12'h000,8'h00,0,0,8'h00,8'h00);
    vecs[8]  = mk(0, 1,1,12'h010,8'h11, 1,1,12'h020,8'h22, 1,0,1,12'h010,8'h11,0,0,8'h00,8'h00);
    vecs[9]  = mk(0, 1,1,12'h010,8'h11, 1,1,12'h020,8'h22, 1,0,0,12'h010,8'h11,1,0,8'h11,8'h00);
    vecs[10] = mk(0, 1,1,12'h010,8'h11, 1,1,12'h020,8'h22, 0,0,0,12'h010,8'h11,0,0,8'h11,8'h00);
    vecs[11] = mk(0, 1,1,12'h010,8'h11, 1,1,12'h020,8'h22, 1,1,1,12'h020,8'h22,0,0,8'h11,8'h00);
    vecs[12] = mk(0, 1,1,12'h010,8'h11, 1,1,12'h020,8'h22, 1,1,0,12'h020,8'h22,0,1,8'h11,8'h22);
    vecs[13] = mk(0, 1,1,12'h010,8'h11, 1,1,12'h020,8'h22, 0,1,0,12'h020,8'h22,0,0,8'h11,8'h22);
    vecs[14] = mk(0, 1,1,12'h010,8'h11, 1,1,12'h020,8'h22, 1,0,1,12'h010,8'h11,0,0,8'h11,8'h22);
    vecs[15] = mk(0, 1,1,12'h010,8'h11, 1,1,12'h020,8'h22, 1,0,0,12'h010,8'h11,1,0,8'h11,8'h22);
    vecs[16] = mk(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,0,12'h010,8'h11,0,0,8'h11,8'h22);
    vecs[17] = mk(0, 1,0,12'h123,8'h00, 0,0,12'h000,8'h00, 1,0,0,12'h123,8'h00,0,0,8'h11,8'h22);
    vecs[18] = mk(0, 1,0,12'h123,8'h00, 0,0,12'h000,8'h00, 1,0,0,12'h123,8'h00,1,0,8'hA5,8'h22);
    vecs[19] = mk(0, 1,0,12'h123,8'h00, 0,0,12'h000,8'h00, 0,0,0,12'h123,8'h00,0,0,8'hA5,8'h22);
    vecs[20] = mk(0, 1,0,12'h123,8'h00, 0,0,12'h000,8'h00, 1,0,0,12'h123,8'h00,0,0,8'hA5,8'h22);
    vecs[21] = mk(0, 1,0,12'h123,8'h00, 0,0,12'h000,8'h00, 1,0,0,12'h123,8'h00,1,0,8'hA5,8'h22);
    vecs[22] = mk(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,0,12'h123,8'h00,0,0,8'hA5,8'h22);
    vecs[23] = mk(0, 0,0,12'h000,8'h00, 1,1,12'hFFF,8'h77, 1,1,1,12'hFFF,8'h77,0,0,8'hA5,8'h22);
    vecs[24] = mk(1, 0,0,12'h000,8'h00, 1,1,12'hFFF,8'h77, 0,0,0,12'h000,8'h00,0,0,8'h00,8'h00);
    vecs[25] = mk(0, 1,0,12'h123,8'h00, 1,1,12'hFFF,8'h77, 1,0,0,12'h123,8'h00,0,0,8'h00,8'h00);
    vecs[26] = mk(0, 1,0,12'h123,8'h00, 1,1,12'hFFF,8'h77, 1,0,0,12'h123,8'h00,1,0,8'hA5,8'h00);
    vecs[27] = mk(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,0,12'h123,8'h00,0,0,8'hA5,8'h00);
    vecs[28] = mk(0, 1,1,12'hFFF,8'h3C, 0,0,12'h000,8'h00, 1,0,1,12'hFFF,8'h3C,0,0,8'hA5,8'h00);
    vecs[29] = mk(0, 1,1,12'hFFF,8'h3C, 0,0,12'h000,8'h00, 1,0,0,12'hFFF,8'h3C,1,0,8'h3C,8'h00);
    vecs[30] = mk(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,0,12'hFFF,8'h3C,0,0,8'h3C,8'h00);
    vecs[31] = mk(0, 0,0,12'h000,8'h00, 1,0,12'hFFF,8'h00, 1,1,0,12'hFFF,8'h00,0,0,8'h3C,8'h00);
    vecs[32] = mk(0, 0,0,12'h000,8'h00, 1,0,12'hFFF,8'h00, 1,1,0,12'hFFF,8'h00,0,1,8'h3C,8'h3C);
    vecs[33] = mk(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,1,0,12'hFFF,8'h00,0,0,8'h3C,8'h3C);

    drive(vecs[0]);
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", outs(), 46'd0);

    for (int i = 0; i < 34; i++) begin
      drive(vecs[i]);
      @(posedge clock);
      #1;
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // m1 arrives while m0 is in flight; it must be served at the first IDLE edge.
    m0_req = 1; m0_we = 1; m0_address = 12'h055; m0_dataout = 8'h99;
    @(posedge clock);
    #1;
    check("m0_start", {45'd0, busy && !grant && ram_we}, 46'd1);
    m1_req = 1; m1_we = 0; m1_address = 12'h055; m1_dataout = 8'h00;
    n = 0; got = 0; m0_seen = 0;
    while (!got && n < 10) begin
      @(posedge clock);
      #1;
      n++;
      if (m0_ack) begin m0_seen = 1; m0_req = 0; end
      if (m1_ack) got = 1;
    end
    m1_req = 0;
    check("m0_ack_seen", {45'd0, m0_seen}, 46'd1);
    check("m1_wait_edges", 46'(n), 46'd4);
    check("m1_got_ack", {45'd0, got}, 46'd1);
    check("m1_read_data", {38'd0, m1_datain}, {38'd0, 8'h99});
    check("m1_grant", {45'd0, grant}, 46'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
